// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port data memory (1-cycle read latency, word
//   addressed, 2^ADDR_LEN x 32) between two requesters:
//     port 0 - CPU load/store unit
//     port 1 - result-check / DMA engine
//   Round-robin arbitration, optional exclusive lock for swap sequences,
//   and routing of read data back to the port that issued the read.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   mN_req/we/lock/addr/wdata port N request (held until granted)
//   mN_gnt                    port N access accepted this cycle (combinational)
//   mN_rvalid/mN_rdata        port N read return, one cycle after the grant
//   mem_addr/wr_req/wr_data   memory drive
//   mem_rd_data               memory read data (one cycle after address)
module mem_port_arbiter #(
  parameter int ADDR_LEN = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic                m0_lock,
  input  logic [ADDR_LEN-1:0] m0_addr,
  input  logic [31:0]         m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [31:0]         m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic                m1_lock,
  input  logic [ADDR_LEN-1:0] m1_addr,
  input  logic [31:0]         m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [31:0]         m1_rdata,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_wr_req,
  output logic [31:0]         mem_wr_data,
  input  logic [31:0]         mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;      // port granted most recently
  logic [ADDR_LEN-1:0]   cnt_q, cnt_d;        // idle cycles spent in a lock
  logic [ADDR_LEN-1:0]   addr_q;
  logic [31:0]           wdata_q;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_owner_q, rd_owner_d;
  logic [31:0]           rdata0_q, rdata1_q;

  logic                  gnt0, gnt1, any_gnt, win;
  logic                  sel_we, sel_lock;
  logic [ADDR_LEN-1:0]   sel_addr;
  logic [31:0]           sel_wdata;

  // Grant decision and next-state logic.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (m0_req && m1_req) begin
            // Conflict: the port that did not win last time goes first.
            gnt0 = last_q;
            gnt1 = ~last_q;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        LOCK0:   gnt0 = m0_req;
        LOCK1:   gnt1 = m1_req;
        default: ;
      endcase
    end

    any_gnt   = gnt0 | gnt1;
    win       = gnt1;
    sel_we    = win ? m1_we    : m0_we;
    sel_lock  = win ? m1_lock  : m0_lock;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;

    if (any_gnt) begin
      last_d  = win;
      cnt_d   = '0;
      state_d = sel_lock ? (win ? LOCK1 : LOCK0) : IDLE;
    end else if (state_q != IDLE) begin
      // Owner went quiet while holding the lock: give up after 2^ADDR_LEN
      // cycles so the other port cannot be starved forever.
      if (cnt_q == '1) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + ADDR_LEN'(1);
      end
    end

    rd_pend_d  = any_gnt & ~sel_we;
    rd_owner_d = win;
  end

  // Memory drive: address/data held from the last cycle when nobody is
  // granted, and the write strobe only ever comes from a granted access.
  assign mem_addr    = any_gnt ? sel_addr  : addr_q;
  assign mem_wr_data = any_gnt ? sel_wdata : wdata_q;
  assign mem_wr_req  = any_gnt & sel_we;

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rd_pend_q & ~rd_owner_q;
  assign m1_rvalid = rd_pend_q &  rd_owner_q;
  // Read data passes straight through in the return cycle and is held after.
  assign m0_rdata  = m0_rvalid ? mem_rd_data : rdata0_q;
  assign m1_rdata  = m1_rvalid ? mem_rd_data : rdata1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      addr_q     <= mem_addr;
      wdata_q    <= mem_wr_data;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rdata0_q   <= m0_rdata;
      rdata1_q   <= m1_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AL = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_lock;
  logic [AL-1:0] m0_addr;
  logic [31:0]   m0_wdata;
  logic          m0_gnt, m0_rvalid;
  logic [31:0]   m0_rdata;
  logic          m1_req, m1_we, m1_lock;
  logic [AL-1:0] m1_addr;
  logic [31:0]   m1_wdata;
  logic          m1_gnt, m1_rvalid;
  logic [31:0]   m1_rdata;
  logic [AL-1:0] mem_addr;
  logic          mem_wr_req;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_LEN(AL)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  // Memory model: 1-cycle registered read, preloaded with a fixed pattern.
  logic          mem_init;
  logic [31:0]   mem [0:(1<<AL)-1];

  function automatic logic [31:0] init_val(input int i);
    if (i == 4)   return 32'h5f;
    if (i == 127) return 32'h57;
    return 32'((i * 51 + 54) & 255);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AL); i++) mem[i] <= init_val(i);
    end else if (mem_wr_req) begin
      mem[mem_addr] <= mem_wr_data;
    end
    mem_rd_data <= mem[mem_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic m0_set(input logic we, input int addr, input logic [31:0] wd, input logic lk);
    m0_req = 1; m0_we = we; m0_addr = AL'(addr); m0_wdata = wd; m0_lock = lk;
  endtask

  task automatic m1_set(input logic we, input int addr, input logic [31:0] wd, input logic lk);
    m1_req = 1; m1_we = we; m1_addr = AL'(addr); m1_wdata = wd; m1_lock = lk;
  endtask

  // Lock sequence for m0: {we, addr, wdata, lock}
  logic        lk_we   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  int          lk_addr [4] = '{85, 24, 85, 24};
  logic [31:0] lk_wd   [4] = '{32'h0, 32'h0, 32'h01, 32'h00};
  logic        lk_lock [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int n;
    int spurious;
    idle_inputs();
    rst = 1'b1;
    mem_init = 1'b1;
    // Requests during reset, including a write, must be ignored.
    m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
    @(negedge clk);
    check_val("rst_m0_gnt", 32'(m0_gnt), 0);
    check_val("rst_m1_gnt", 32'(m1_gnt), 0);
    check_val("rst_wr_req", 32'(mem_wr_req), 0);
    check_val("rst_m0_rvalid", 32'(m0_rvalid), 0);
    check_val("rst_m1_rvalid", 32'(m1_rvalid), 0);
    check_val("rst_m0_rdata", m0_rdata, 0);
    check_val("rst_m1_rdata", m1_rdata, 0);
    next_cycle();
    mem_init = 1'b0;
    idle_inputs();
    rst = 1'b0;

    // Single port 0 read of address 0.
    m0_set(0, 0, 0, 0);
    @(negedge clk);
    check_val("p0rd_gnt", 32'(m0_gnt), 1);
    check_val("p0rd_m1_gnt", 32'(m1_gnt), 0);
    check_val("p0rd_addr", 32'(mem_addr), 0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_val("p0rd_rvalid", 32'(m0_rvalid), 1);
    check_val("p0rd_rdata", m0_rdata, 32'h36);
    check_val("p0rd_m1_rvalid", 32'(m1_rvalid), 0);
    next_cycle();
    @(negedge clk);
    check_val("p0rd_rvalid_off", 32'(m0_rvalid), 0);
    check_val("p0rd_rdata_hold", m0_rdata, 32'h36);
    next_cycle();

    // Both ports read continuously: grants alternate starting with m0.
    do_reset();
    m0_set(0, 1, 0, 0);
    m1_set(0, 127, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val($sformatf("rr_m0_gnt%0d", k), 32'(m0_gnt), 32'((k % 2) == 0));
      check_val($sformatf("rr_m1_gnt%0d", k), 32'(m1_gnt), 32'((k % 2) == 1));
      if (k == 1 || k == 3) begin
        check_val($sformatf("rr_m0_rv%0d", k), 32'(m0_rvalid), 1);
        check_val($sformatf("rr_m0_rd%0d", k), m0_rdata, 32'h69);
        check_val($sformatf("rr_m1_rv%0d", k), 32'(m1_rvalid), 0);
      end else if (k == 2) begin
        check_val($sformatf("rr_m1_rv%0d", k), 32'(m1_rvalid), 1);
        check_val($sformatf("rr_m1_rd%0d", k), m1_rdata, 32'h57);
        check_val($sformatf("rr_m0_rv%0d", k), 32'(m0_rvalid), 0);
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check_val("rr_m1_rv_last", 32'(m1_rvalid), 1);
    check_val("rr_m1_rd_last", m1_rdata, 32'h57);
    check_val("rr_m0_rv_last", 32'(m0_rvalid), 0);
    next_cycle();

    // m0 lock / swap sequence while m1 waits on address 0.
    do_reset();
    m1_set(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      m0_set(lk_we[k], lk_addr[k], lk_wd[k], lk_lock[k]);
      @(negedge clk);
      check_val($sformatf("lk_m0_gnt%0d", k), 32'(m0_gnt), 1);
      check_val($sformatf("lk_m1_gnt%0d", k), 32'(m1_gnt), 0);
      check_val($sformatf("lk_wr%0d", k), 32'(mem_wr_req), 32'(lk_we[k]));
      if (k == 1) check_val("lk_rd85", m0_rdata, 32'h25);
      if (k == 2) check_val("lk_rd24", m0_rdata, 32'hFE);
      if (k == 3) check_val("lk_rv_wr", 32'(m0_rvalid), 0);
      next_cycle();
    end
    m0_req = 0; m0_we = 0; m0_lock = 0;
    @(negedge clk);
    check_val("lk_m1_gnt_after", 32'(m1_gnt), 1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_val("lk_m1_rv", 32'(m1_rvalid), 1);
    check_val("lk_m1_rd", m1_rdata, 32'h36);
    next_cycle();
    m0_set(0, 85, 0, 0);
    @(negedge clk);
    check_val("lk_reread_gnt", 32'(m0_gnt), 1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_val("lk_reread85", m0_rdata, 32'h01);
    next_cycle();

    // Port 1 write followed by port 0 read of the same address.
    do_reset();
    m1_set(1, 5, 32'hDEADBEEF, 0);
    @(negedge clk);
    check_val("wr_m1_gnt", 32'(m1_gnt), 1);
    check_val("wr_req", 32'(mem_wr_req), 1);
    check_val("wr_addr", 32'(mem_addr), 5);
    check_val("wr_data", mem_wr_data, 32'hDEADBEEF);
    next_cycle();
    idle_inputs();
    m0_set(0, 5, 0, 0);
    @(negedge clk);
    check_val("wr_rd_gnt", 32'(m0_gnt), 1);
    check_val("wr_rd_noreq", 32'(mem_wr_req), 0);
    next_cycle();
    m0_set(0, 4, 0, 0);
    @(negedge clk);
    check_val("wr_rd5", m0_rdata, 32'hDEADBEEF);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_val("wr_rd4", m0_rdata, 32'h5f);
    check_val("nogrant_wr", 32'(mem_wr_req), 0);
    check_val("nogrant_addr_hold", 32'(mem_addr), 4);
    next_cycle();

    // Reset arriving while a port 1 read return is pending.
    do_reset();
    m1_set(0, 2, 0, 0);
    @(negedge clk);
    check_val("rs_m1_gnt", 32'(m1_gnt), 1);
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    check_val("rs_m1_rv_in_rst", 32'(m1_rvalid), 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_val("rs_m1_rv_after", 32'(m1_rvalid), 0);
    next_cycle();
    m0_set(0, 3, 0, 0);
    m1_set(0, 6, 0, 0);
    @(negedge clk);
    check_val("rs_m0_first", 32'(m0_gnt), 1);
    check_val("rs_m1_held", 32'(m1_gnt), 0);
    next_cycle();

    // Lock timeout: m1 locks then goes quiet; m0 waits exactly 2^AL cycles.
    do_reset();
    m1_set(0, 9, 0, 1);
    @(negedge clk);
    check_val("to_m1_gnt", 32'(m1_gnt), 1);
    next_cycle();
    idle_inputs();
    m0_set(0, 0, 0, 0);
    n = 0;
    spurious = 0;
    @(negedge clk);
    while (m0_gnt !== 1'b1 && n < 3000) begin
      if (mem_wr_req !== 1'b0 || m1_gnt !== 1'b0) spurious++;
      n++;
      @(negedge clk);
    end
    check_val("to_wait_cycles", 32'(n), 32'(1 << AL));
    check_val("to_m0_gnt", 32'(m0_gnt), 1);
    check_val("to_no_spurious", 32'(spurious), 0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_val("to_m0_rd", m0_rdata, 32'h36);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
